// File: rtl/apb_mem_slave.sv
// APB3/APB4 slave backed by a single-port register-array RAM.
// The data width, depth and number of wait states are parameters. Writes use byte strobes.
// A misaligned or out-of-range address returns an error response.
module apb_mem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    Pclk,
  input  logic                    Prst,
  input  logic                    Pselx,
  input  logic                    Penable,
  input  logic                    Pwrite,
  input  logic [ADDR_WIDTH-1:0]   Paddr,
  input  logic [DATA_WIDTH-1:0]   Pwdata,
  input  logic [DATA_WIDTH/8-1:0] Pstrb,
  output logic                    Pready,
  output logic                    Pslverr,
  output logic [DATA_WIDTH-1:0]   Prdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned LsbW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic StIdle   = 1'b0;
  localparam logic StAccess = 1'b1;

  // Byte-offset bits within a word; these must be zero for an aligned access.
  localparam logic [ADDR_WIDTH-1:0] LowMask = ADDR_WIDTH'((1 << LsbW) - 1);

  logic                  state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NumBytes-1:0]   strb_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_err;
  logic                  setup;
  logic                  complete;

  // Decode the address and derive the phase events from the bus and the registered state.
  always_comb begin
    word_idx = Paddr >> LsbW;
    addr_err = (|(Paddr & LowMask)) || (32'(word_idx) >= DEPTH);
    setup    = (state_q == StIdle) && Pselx && !Penable;
    complete = Pready && Pselx && Penable;
  end

  // Outputs come from registered state only, so no bus input reaches an output combinationally.
  always_comb begin
    Pready  = (state_q == StAccess) && (cnt_q == 4'd0);
    Pslverr = Pready && err_q;
    Prdata  = prdata_q;
  end

  // Next-state logic: IDLE goes to ACCESS on a setup phase.
  // ACCESS returns to IDLE on completion, or on an abort when the select or enable drops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    if (state_q == StIdle) begin
      if (setup) begin
        state_d  = StAccess;
        cnt_d    = 4'(WAIT_STATES);
        prdata_d = (addr_err || Pwrite) ? '0 : mem_q[word_idx[IdxW-1:0]];
      end
    end else begin
      if (!Pselx || !Penable || complete) begin
        state_d = StIdle;
      end else if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Registers for the control and transfer state. Reset clears the whole array.
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      if (setup) begin
        idx_q   <= word_idx[IdxW-1:0];
        write_q <= Pwrite;
        wdata_q <= Pwdata;
        strb_q  <= Pstrb;
        err_q   <= addr_err;
      end
      // A write is committed only on the completing edge, and only when no error was flagged.
      if (complete && write_q && !err_q) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (strb_q[b]) begin
            mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave memory: a single-port register-array RAM behind an APB3/APB4 slave interface. It adds configurable data width, depth, and wait states, plus byte strobes and address error reporting. It is the successor to the fixed 32x32 APB memory, sits on the peripheral bus below the APB bridge, and is the standard memory-mapped storage target for protocol test benches.

## Interface
- DATA_WIDTH, 32, bus and word width; legal values 8, 16, 32, 64.
- ADDR_WIDTH, 8, width of the byte address on Paddr.
- DEPTH, 32, number of words; must be ≤ 2^(ADDR_WIDTH−log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, Pready-low cycles inserted in every access phase; legal range 0..15.
- Pclk  in  1  clock; all logic on the rising edge.
- Prst  in  1  reset; synchronous and active-high.
- Pselx  in  1  slave select.
- Penable  in  1  access-phase strobe.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  ADDR_WIDTH  byte address.
- Pwdata  in  DATA_WIDTH  write data.
- Pstrb  in  DATA_WIDTH/8  byte-lane write enables.
- Pready  out  1  transfer-complete indication.
- Pslverr  out  1  error response; valid only while Pready=1.
- Prdata  out  DATA_WIDTH  read data; valid while Pready=1 on a read.

## Operation
- Word index is Paddr >> log2(DATA_WIDTH/8). Low address bits must be zero.
- An error condition exists when the low address bits are nonzero (misaligned) or the word index is ≥ DEPTH.
- The FSM has two states, IDLE and ACCESS.
- In IDLE, Pselx=1 and Penable=0 (setup phase) moves the FSM to ACCESS. On that edge the block:
  - latches index, Pwrite, Pwdata, Pstrb, and the error flag;
  - loads the wait counter with WAIT_STATES;
  - loads Prdata with mem[index], or with 0 if the error flag is set or the transfer is a write.
- In IDLE, Pselx=1 with Penable=1 (access without setup) is ignored: no state change and no memory update.
- In ACCESS, while the counter is nonzero it decrements each cycle.
- Pready = (state==ACCESS) && (counter==0).
- Pslverr = Pready && latched error flag.
- The transfer completes on an edge where Pready=1, Pselx=1, and Penable=1. On that edge:
  - a non-error write updates each byte lane i of mem[index] where Pstrb[i]=1 (Pstrb=0 leaves the word unchanged);
  - an error write leaves memory untouched;
  - the FSM returns to IDLE.
- Abort: in ACCESS, if Pselx=0 or Penable=0 on any edge, the FSM returns to IDLE, no write occurs, and latched data is discarded.
- Reads ignore Pstrb and Pwdata.
- Prdata holds its last loaded value between transfers.
- Reset values: state=IDLE, counter=0, Pready=0, Pslverr=0, Prdata=0, and all DEPTH words cleared to 0.
- Reset mid-transfer aborts the transfer: a write in progress is not committed, and memory is cleared.

## Timing
- Setup cycle to first Pready=1: 1 + WAIT_STATES cycles.
- Total transfer length is 2 + WAIT_STATES cycles.
- Back-to-back transfers are supported. The setup phase of transfer N+1 may occur in the cycle immediately after the completing edge of transfer N, because the FSM is in IDLE then.
- A write followed by a read of the same address returns the new data. The write commits on the completing edge, and the read loads Prdata at its setup edge, which is later.
- Pready and Pslverr are decoded from registered state only. No combinational path exists from any APB input to any output.

## Test plan
- Reset, then write 0xDEADBEEF at address 0x08, then read 0x08. Expected: Prdata=0xDEADBEEF and Pslverr=0; both transfers take 2 cycles with WAIT_STATES=0.
- Write 0x11223344 at address 0x10, then write 0xAABBCCDD at 0x10 with Pstrb=4'b0101, then read 0x10. Expected: 0x11BB33DD.
- With DEPTH=32 and DATA_WIDTH=32: write to 0x80 (out of range) and read 0x02 (misaligned). Expected: Pslverr=1 with Pready on both, read Prdata=0, and a follow-up read of all valid words shows no change.
- With WAIT_STATES=3: read 0x04. Expected: Pready low for exactly 3 access cycles, high on the 4th, transfer length 5 cycles.
- With WAIT_STATES=2: drop Penable during the wait cycles of a write of 0x55 to 0x0C. Expected: FSM in IDLE on the next cycle, and a read of 0x0C returns 0.
- Assert Prst during the access phase of a write, then read back every word. Expected: all outputs are 0 on the cycle after reset and every word reads 0.
